// File: rtl/uart_if_pkg.sv
// ============================================================================
// Module   : uart_if_pkg
// Brief    : Shared opcodes, FSM state type and data-width default for the
//            UART command/response ALU stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_if_pkg;

    localparam int DBIT_DEFAULT = 8;

    // MIPS funct field encodings
    localparam logic [7:0] OP_SRL = 8'h02;
    localparam logic [7:0] OP_SRA = 8'h03;
    localparam logic [7:0] OP_ADD = 8'h20;
    localparam logic [7:0] OP_SUB = 8'h22;
    localparam logic [7:0] OP_AND = 8'h24;
    localparam logic [7:0] OP_OR  = 8'h25;
    localparam logic [7:0] OP_XOR = 8'h26;
    localparam logic [7:0] OP_NOR = 8'h27;

    typedef enum logic [2:0] {
        GET_A  = 3'd0,
        GET_B  = 3'd1,
        GET_OP = 3'd2,
        EXEC   = 3'd3,
        SEND   = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/uart_alu_interface_alu.sv
// ============================================================================
// Module   : alu
// Brief    : Purely combinational ALU keyed by MIPS funct codes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu
    import uart_if_pkg::*;
#(
    parameter int DBIT = DBIT_DEFAULT
) (
    input  logic [DBIT-1:0] a,
    input  logic [DBIT-1:0] b,
    input  logic [DBIT-1:0] op,
    output logic [DBIT-1:0] result,
    output logic            op_err
);

    localparam int SHW = (DBIT > 1) ? $clog2(DBIT) : 1;

    logic [SHW-1:0] shamt;
    assign shamt = b[SHW-1:0];

    always_comb begin
        result = '0;
        op_err = 1'b0;
        case (op)
            DBIT'(OP_ADD): result = a + b;
            DBIT'(OP_SUB): result = a - b;
            DBIT'(OP_AND): result = a & b;
            DBIT'(OP_OR):  result = a | b;
            DBIT'(OP_XOR): result = a ^ b;
            DBIT'(OP_NOR): result = ~(a | b);
            DBIT'(OP_SRL): result = a >> shamt;
            DBIT'(OP_SRA): result = $unsigned($signed(a) >>> shamt);
            default:       op_err = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/uart_alu_interface.sv
// ============================================================================
// Module   : uart_alu_interface
// Brief    : Pops an (A, B, opcode) frame from the UART RX FIFO, executes it
//            and pushes the one-byte result to the TX FIFO. Optional
//            inter-byte timeout enabled by UART_IF_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_alu_interface
    import uart_if_pkg::*;
#(
    parameter int DBIT    = DBIT_DEFAULT,
    parameter int TIMEOUT = 100000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx_empty,
    input  logic [DBIT-1:0] r_data,
    output logic            rd_uart,
    input  logic            tx_full,
    output logic [DBIT-1:0] w_data,
    output logic            wr_uart,
    output logic [DBIT-1:0] alu_result,
    output logic            zero,
    output logic            op_err,
    output logic            timeout_err,
    output logic            busy
);

    state_t          state_q, state_d;
    logic [DBIT-1:0] a_q, b_q, op_q;
    logic [DBIT-1:0] result_q;
    logic            zero_q, op_err_q;
    logic [DBIT-1:0] alu_res;
    logic            alu_err;
    logic            tmo_expire;

    alu #(.DBIT(DBIT)) u_alu (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (alu_res),
        .op_err (alu_err)
    );

    // Strobes are gated by reset so nothing is popped or pushed in a reset cycle
    always_comb begin
        state_d = state_q;
        rd_uart = 1'b0;
        wr_uart = 1'b0;
        case (state_q)
            GET_A: begin
                if (!rx_empty) begin
                    rd_uart = 1'b1;
                    state_d = GET_B;
                end
            end
            GET_B: begin
                if (!rx_empty) begin
                    rd_uart = 1'b1;
                    state_d = GET_OP;
                end else if (tmo_expire) begin
                    state_d = GET_A;
                end
            end
            GET_OP: begin
                if (!rx_empty) begin
                    rd_uart = 1'b1;
                    state_d = EXEC;
                end else if (tmo_expire) begin
                    state_d = GET_A;
                end
            end
            EXEC: state_d = SEND;
            SEND: begin
                if (!tx_full) begin
                    wr_uart = 1'b1;
                    state_d = GET_A;
                end
            end
            default: state_d = GET_A;
        endcase
        if (reset) begin
            rd_uart = 1'b0;
            wr_uart = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= GET_A;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            op_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (rd_uart) begin
                case (state_q)
                    GET_A:   a_q  <= r_data;
                    GET_B:   b_q  <= r_data;
                    GET_OP:  op_q <= r_data;
                    default: ;
                endcase
            end
            if (state_q == EXEC) begin
                result_q <= alu_res;
                zero_q   <= (alu_res == '0);
                op_err_q <= alu_err;
            end
        end
    end

`ifdef UART_IF_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] tmo_cnt_q;
    logic          tmo_q;
    logic          in_wait;

    assign in_wait = (state_q == GET_B) || (state_q == GET_OP);

    // A pop in the expiry cycle takes priority because rd_uart is checked first
    always_comb begin
        tmo_expire = in_wait && rx_empty && (tmo_cnt_q == CW'(TIMEOUT - 1));
    end

    always_ff @(posedge clk) begin
        if (reset || rd_uart || !in_wait) begin
            tmo_cnt_q <= '0;
        end else if (rx_empty) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
        if (reset) begin
            tmo_q <= 1'b0;
        end else begin
            tmo_q <= tmo_expire;
        end
    end

    assign timeout_err = tmo_q;
`else
    assign tmo_expire  = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign w_data     = result_q;
    assign alu_result = result_q;
    assign zero       = zero_q;
    assign op_err     = op_err_q;
    assign busy       = (state_q != GET_A);

endmodule

`default_nettype wire

// File: doc/uart_alu_interface.md
# uart_alu_interface

- Command/response stage that sits directly downstream of the `uart` block's RX FIFO and upstream of its TX FIFO.
- Collects a 3-byte frame (operand A, operand B, opcode) from the RX FIFO and executes it on a combinational ALU.
- Registers the result, then writes it as one byte into the TX FIFO.
- Also drives the last result and status flags to board-level outputs (LEDs).

## Interface
- `DBIT`, 8, data/operand width; must match the UART data width.
- `TIMEOUT`, 100000, inter-byte timeout in clock cycles; used only when `UART_IF_TIMEOUT_EN` is defined.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `rx_empty`  in  1  RX FIFO empty.
- `r_data`  in  DBIT  RX FIFO head word; valid whenever `rx_empty`=0.
- `rd_uart`  out  1  RX FIFO pop strobe.
- `tx_full`  in  1  TX FIFO full.
- `w_data`  out  DBIT  byte pushed to TX FIFO.
- `wr_uart`  out  1  TX FIFO push strobe.
- `alu_result`  out  DBIT  last registered result.
- `zero`  out  1  `alu_result`==0.
- `op_err`  out  1  last opcode was undefined.
- `timeout_err`  out  1  one-cycle pulse when a partial frame is dropped.
- `busy`  out  1  high in every state except GET_A.

## Operation
- FSM states: GET_A → GET_B → GET_OP → EXEC → SEND → GET_A.
- **GET_x:** when `rx_empty`=0, assert `rd_uart` for that cycle, latch `r_data` into `a`/`b`/`op`, advance next cycle. When `rx_empty`=1, hold with `rd_uart`=0.
- **EXEC:** register the ALU output into `alu_result`, update `zero` and `op_err`.
- **SEND:** when `tx_full`=0, assert `wr_uart` for one cycle with `w_data`=`alu_result`, then go to GET_A. When `tx_full`=1, hold with `wr_uart`=0 and `w_data` stable.
- Opcodes (MIPS funct):
  - ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, XOR 0x26, NOR 0x27: A op B.
  - SRL 0x02, SRA 0x03: A shifted by `B[$clog2(DBIT)-1:0]`.
- ADD/SUB wrap modulo 2^DBIT; carry/borrow is discarded.
- Undefined opcode: result 0, `op_err`=1, and the result is still sent, so every frame produces exactly one TX byte.
- `rd_uart` is asserted only when `rx_empty`=0; `wr_uart` only when `tx_full`=0. Neither is ever asserted for two bytes in one cycle.
- Reset at any point, including mid-frame or during SEND: return to GET_A and discard partial operands. No `wr_uart` is issued in the reset cycle.
- Reset values: `rd_uart`, `wr_uart`, `w_data`, `alu_result`, `op_err`, `timeout_err`, `busy` = 0; `zero`=1.

## Timing
- Back-to-back bytes available: `rd_uart` high in cycles 0, 1, 2; EXEC in cycle 3; `wr_uart` in cycle 4.
  - Latency from first pop to push: 4 cycles.
  - Maximum throughput: one frame per 5 cycles.
- `alu_result`, `zero` and `op_err` update at the end of EXEC and hold until the next EXEC.
- `r_data` is sampled in the same cycle `rd_uart` is asserted; the FIFO advances on that edge.

## Configuration
- Macro: `UART_IF_TIMEOUT_EN`.
- **Defined:**
  - A counter runs in GET_B and GET_OP while `rx_empty`=1; it is cleared on every pop and on entry to GET_A.
  - When the count reaches `TIMEOUT`-1, the FSM returns to GET_A, drops the partial frame, pulses `timeout_err` for one cycle, and sends no TX byte.
  - If a byte arrives in the same cycle the count expires, the pop wins and no timeout occurs.
- **Undefined:** no counter is built; `timeout_err` is tied to 0; GET states wait indefinitely.

## Structure
- Package `uart_if_pkg`: opcode localparams, FSM state enum `state_t`, and the `DBIT` default.
- Sub-module `alu`: purely combinational, inputs `a`, `b`, `op`, outputs `result` and `op_err`. It is reused by the ALU lab top.
- The interface module holds only the FSM, operand registers, result register and the optional timeout counter.

## Test plan
- RX bytes 0x05, 0x03, 0x20 with TX not full → exactly one push of 0x08, 4 cycles after the first `rd_uart`; `zero`=0, `op_err`=0.
- Frame 0x03, 0x05, 0x22 → push 0xFE (wrap). Frame 0x80, 0x02, 0x03 → push 0xE0. Frame 0x80, 0x02, 0x02 → push 0x20.
- Frame 0x0F, 0x0F, 0x26 → push 0x00 with `zero`=1. Frame 0x01, 0x01, 0x55 → push 0x00 with `op_err`=1.
- `tx_full` held high 10 cycles in SEND → `wr_uart` stays 0 and `w_data` stable; one push occurs in the cycle after `tx_full` falls.
- `reset` asserted after 2 of 3 bytes → all outputs return to reset values; next full frame 0x02, 0x02, 0x24 → push 0x02.
- With `UART_IF_TIMEOUT_EN` and `TIMEOUT`=20: send one byte then idle 20 cycles → single `timeout_err` pulse, no push; next frame computes correctly.
